mir_queue: RTL and testbench

Parametrised successor to the card-1006 microinstruction register for the NORD-10/S core. It assembles microinstruction words from the 32-bit microprogram ROM output and IR operand fields, and holds them in a DEPTH-entry prefetch queue. The microsequencer can fetch ahead of execution this way. The head entry drives the existing MIR consumers: B-input shift select, bitmask source and level mux.

---
 rtl/mir_queue.sv | 140 ++++++++++++++
 tb/tb_mir_queue.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mir_queue.sv
// Microinstruction register prefetch queue: assembles {ROM, IR} words at push time and presents the head entry to the MIR consumers.
// Optional ROM parity checking is built when MIRQ_PARITY_EN is defined (adds ROMP input and sticky MIRPE output).
module mir_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned LEVW  = 4
) (
    input  logic                     clk,
    input  logic                     MCLn,
    input  logic [31:0]              ROM,
    input  logic [15:0]              IR,
    input  logic                     MIRKL,
    output logic                     MIRRDY,
    input  logic                     MIRNX,
    input  logic                     FLUSH,
    output logic                     MIRV,
    output logic [15:0]              MIR15_0,
    input  logic                     TC1,
    output logic [2:0]               SL,
    output logic                     BMSRC,
    input  logic                     LSEL,
    input  logic                     MOPC,
    input  logic [LEVW-1:0]          PIL,
    output logic [LEVW-1:0]          LEV,
    output logic [$clog2(DEPTH):0]   CNT
`ifdef MIRQ_PARITY_EN
    ,
    input  logic                     ROMP,
    output logic                     MIRPE
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    // Build the microinstruction word from the ROM field code and IR operand fields.
    function automatic logic [15:0] assemble(input logic [18:0] rom, input logic [10:0] ir);
        logic [15:0] w;
        w = rom[15:0];
        case (rom[18:16])
            3'd1: w = {ir[6:3], rom[11:4], (ir[2:0] == 3'd0) ? 4'h8 : {1'b0, ir[2:0]}};
            3'd3: w = {ir[6:3], rom[11:8], rom[7:4], 1'b0, ir[2:0]};
            3'd4: w = {rom[15], ir[10:8], rom[11:0]};
            3'd5, 3'd6: begin
                w = {rom[15:12], 1'b0, ir[2:0], rom[7:4], 1'b0, ir[2:0]};
                if (rom[18:16] == 3'd6 && ir[6]) begin
                    w[6:4] = 3'b000;
                end
            end
            3'd7: w = {rom[15:12], 1'b0, ir[5:3], rom[7:4], 1'b0, ir[2:0]};
            default: w = rom[15:0];
        endcase
        return w;
    endfunction

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] rptr, rptr_nx;
    logic [PW-1:0] wptr, wptr_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          full, empty;
    logic          push_ok, pop_ok, push_acc;
    logic [15:0]   word;
    logic [15:0]   head;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign pop_ok   = MIRNX && !empty;
    assign push_ok  = MIRKL && (!full || MIRNX);
    assign push_acc = push_ok && !FLUSH;
    assign word     = assemble(ROM[18:0], IR[10:0]);

    // Pointer and occupancy next state; FLUSH overrides any push/pop.
    always_comb begin
        rptr_nx = rptr;
        wptr_nx = wptr;
        cnt_nx  = cnt;
        if (FLUSH) begin
            rptr_nx = '0;
            wptr_nx = '0;
            cnt_nx  = '0;
        end else begin
            if (push_ok) begin
                wptr_nx = wptr + PW'(1);
            end
            if (pop_ok) begin
                rptr_nx = rptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_nx = cnt + CW'(1);
                2'b01:   cnt_nx = cnt - CW'(1);
                default: cnt_nx = cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!MCLn) begin
            rptr <= '0;
            wptr <= '0;
            cnt  <= '0;
        end else begin
            rptr <= rptr_nx;
            wptr <= wptr_nx;
            cnt  <= cnt_nx;
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (MCLn && push_acc) begin
            mem[wptr] <= word;
        end
    end

    assign head    = empty ? 16'h0000 : mem[rptr];
    assign MIR15_0 = head;
    assign MIRV    = !empty;
    assign MIRRDY  = !full || MIRNX;
    assign CNT     = cnt;
    assign SL      = head[7] ? head[6:4] : {2'b00, TC1};
    assign BMSRC   = (head[7:4] == 4'b1010);
    assign LEV     = LSEL ? LEVW'(head[15:12]) : (MOPC ? '0 : PIL);

`ifdef MIRQ_PARITY_EN
    // Sticky error when an accepted ROM word fails odd parity; the word is still queued.
    always_ff @(posedge clk) begin
        if (!MCLn) begin
            MIRPE <= 1'b0;
        end else if (push_acc && !(^{ROMP, ROM})) begin
            MIRPE <= 1'b1;
        end
    end

    logic unused_ir;
    assign unused_ir = ^IR[15:11];
`else
    logic unused_bits;
    assign unused_bits = ^{ROM[31:19], IR[15:11]};
`endif

endmodule

// File: tb/tb_mir_queue.sv
// Directed self-checking bench for mir_queue (DEPTH=4, LEVW=4); parity checks are built when MIRQ_PARITY_EN is defined.
module tb_mir_queue;

    logic        clk = 1'b0;
    logic        MCLn, MIRKL, MIRNX, FLUSH, TC1, LSEL, MOPC;
    logic [31:0] ROM;
    logic [15:0] IR;
    logic [3:0]  PIL;
    logic        MIRRDY, MIRV, BMSRC;
    logic [15:0] MIR15_0;
    logic [2:0]  SL;
    logic [3:0]  LEV;
    logic [2:0]  CNT;
`ifdef MIRQ_PARITY_EN
    logic        ROMP, MIRPE;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mir_queue #(.DEPTH(4), .LEVW(4)) dut (
        .clk(clk), .MCLn(MCLn), .ROM(ROM), .IR(IR), .MIRKL(MIRKL), .MIRRDY(MIRRDY),
        .MIRNX(MIRNX), .FLUSH(FLUSH), .MIRV(MIRV), .MIR15_0(MIR15_0), .TC1(TC1),
        .SL(SL), .BMSRC(BMSRC), .LSEL(LSEL), .MOPC(MOPC), .PIL(PIL), .LEV(LEV), .CNT(CNT)
`ifdef MIRQ_PARITY_EN
        , .ROMP(ROMP), .MIRPE(MIRPE)
`endif
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] rom, input logic [15:0] ir);
        ROM = rom; IR = ir; MIRKL = 1'b1;
        cyc();
        MIRKL = 1'b0; IR = 16'hFFFF; ROM = 32'h0;
        #1;
    endtask

    task automatic pop();
        MIRNX = 1'b1;
        cyc();
        MIRNX = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        MCLn = 1'b0;
        cyc();
        MCLn = 1'b1;
        #1;
        n_tests++; if (MIRV !== 1'b0) begin n_fail++; $display("FAIL reset_mirv got %b exp 0", MIRV); end
        n_tests++; if (MIR15_0 !== 16'h0) begin n_fail++; $display("FAIL reset_mir got %h exp 0000", MIR15_0); end
        n_tests++; if (CNT !== 3'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", CNT); end
        n_tests++; if (MIRRDY !== 1'b1) begin n_fail++; $display("FAIL reset_mirrdy got %b exp 1", MIRRDY); end
    endtask

    task automatic test_code0();
        push(32'h0000_1234, 16'h0000);
        n_tests++; if (MIRV !== 1'b1) begin n_fail++; $display("FAIL code0_mirv got %b exp 1", MIRV); end
        n_tests++; if (MIR15_0 !== 16'h1234) begin n_fail++; $display("FAIL code0_mir got %h exp 1234", MIR15_0); end
        n_tests++; if (CNT !== 3'd1) begin n_fail++; $display("FAIL code0_cnt got %0d exp 1", CNT); end
        pop();
        n_tests++; if (CNT !== 3'd0) begin n_fail++; $display("FAIL code0_pop_cnt got %0d exp 0", CNT); end
    endtask

    task automatic test_assembly();
        logic [31:0] roms [9];
        logic [15:0] irs  [9];
        logic [15:0] exps [9];
        roms = '{32'h0001_0F50, 32'h0003_ABCD, 32'h0004_9876, 32'h0005_1234, 32'h0006_ABFF,
                 32'h0006_ABFF, 32'h0007_5C3E, 32'h0002_BEEF, 32'h0001_0F50};
        irs  = '{16'h0078, 16'h005D, 16'h0500, 16'h0007, 16'h0042,
                 16'h0002, 16'h002B, 16'hFFFF, 16'h0003};
        exps = '{16'hFF58, 16'hBBC5, 16'hD876, 16'h1737, 16'hA282,
                 16'hA2F2, 16'h5533, 16'hBEEF, 16'h0F53};
        TC1 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            push(roms[i], irs[i]);
            n_tests++;
            if (MIR15_0 !== exps[i]) begin
                n_fail++; $display("FAIL assemble[%0d] got %h exp %h", i, MIR15_0, exps[i]);
            end
            if (i == 0) begin
                n_tests++; if (SL !== 3'b001) begin n_fail++; $display("FAIL code1_sl got %b exp 001", SL); end
                n_tests++; if (BMSRC !== 1'b0) begin n_fail++; $display("FAIL code1_bmsrc got %b exp 0", BMSRC); end
            end
            pop();
        end
        TC1 = 1'b0;
    endtask

    task automatic test_sl_bmsrc();
        TC1 = 1'b1;
        push(32'h0000_00A0, 16'h0000);
        n_tests++; if (SL !== 3'b010) begin n_fail++; $display("FAIL sl_head got %b exp 010", SL); end
        n_tests++; if (BMSRC !== 1'b1) begin n_fail++; $display("FAIL bmsrc_head got %b exp 1", BMSRC); end
        pop();
        n_tests++; if (SL !== 3'b001) begin n_fail++; $display("FAIL sl_empty got %b exp 001", SL); end
        n_tests++; if (BMSRC !== 1'b0) begin n_fail++; $display("FAIL bmsrc_empty got %b exp 0", BMSRC); end
        TC1 = 1'b0;
        #1;
        n_tests++; if (SL !== 3'b000) begin n_fail++; $display("FAIL sl_empty_tc0 got %b exp 000", SL); end
    endtask

    task automatic test_full_wrap();
        logic [15:0] order [4];
        order = '{16'h2222, 16'h3333, 16'h4444, 16'h6666};
        push(32'h0000_1111, 16'h0); push(32'h0000_2222, 16'h0);
        push(32'h0000_3333, 16'h0); push(32'h0000_4444, 16'h0);
        n_tests++; if (CNT !== 3'd4) begin n_fail++; $display("FAIL full_cnt got %0d exp 4", CNT); end
        n_tests++; if (MIRRDY !== 1'b0) begin n_fail++; $display("FAIL full_mirrdy got %b exp 0", MIRRDY); end
        push(32'h0000_5555, 16'h0);
        n_tests++; if (CNT !== 3'd4) begin n_fail++; $display("FAIL overflow_cnt got %0d exp 4", CNT); end
        n_tests++; if (MIR15_0 !== 16'h1111) begin n_fail++; $display("FAIL overflow_head got %h exp 1111", MIR15_0); end
        MIRNX = 1'b1; #1;
        n_tests++; if (MIRRDY !== 1'b1) begin n_fail++; $display("FAIL full_pop_mirrdy got %b exp 1", MIRRDY); end
        ROM = 32'h0000_6666; MIRKL = 1'b1;
        cyc();
        MIRKL = 1'b0; MIRNX = 1'b0; #1;
        n_tests++; if (CNT !== 3'd4) begin n_fail++; $display("FAIL full_pushpop_cnt got %0d exp 4", CNT); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (MIR15_0 !== order[i]) begin
                n_fail++; $display("FAIL wrap_order[%0d] got %h exp %h", i, MIR15_0, order[i]);
            end
            pop();
        end
        n_tests++; if (MIRV !== 1'b0) begin n_fail++; $display("FAIL drain_mirv got %b exp 0", MIRV); end
        pop();
        n_tests++; if (CNT !== 3'd0) begin n_fail++; $display("FAIL empty_pop_cnt got %0d exp 0", CNT); end
        ROM = 32'h0000_7777; MIRKL = 1'b1; MIRNX = 1'b1;
        cyc();
        n_tests++; if (CNT !== 3'd1) begin n_fail++; $display("FAIL empty_pushpop_cnt got %0d exp 1", CNT); end
        n_tests++; if (MIR15_0 !== 16'h7777) begin n_fail++; $display("FAIL empty_pushpop_head got %h exp 7777", MIR15_0); end
        ROM = 32'h0000_8888;
        cyc();
        MIRKL = 1'b0; MIRNX = 1'b0; #1;
        n_tests++; if (CNT !== 3'd1) begin n_fail++; $display("FAIL one_pushpop_cnt got %0d exp 1", CNT); end
        n_tests++; if (MIR15_0 !== 16'h8888) begin n_fail++; $display("FAIL one_pushpop_head got %h exp 8888", MIR15_0); end
        pop();
    endtask

    task automatic test_flush();
        push(32'h0000_0101, 16'h0); push(32'h0000_0202, 16'h0); push(32'h0000_0303, 16'h0);
        ROM = 32'h0000_9999; MIRKL = 1'b1; FLUSH = 1'b1;
        cyc();
        MIRKL = 1'b0; FLUSH = 1'b0; #1;
        n_tests++; if (CNT !== 3'd0) begin n_fail++; $display("FAIL flush_cnt got %0d exp 0", CNT); end
        n_tests++; if (MIRV !== 1'b0) begin n_fail++; $display("FAIL flush_mirv got %b exp 0", MIRV); end
        n_tests++; if (MIR15_0 !== 16'h0) begin n_fail++; $display("FAIL flush_mir got %h exp 0000", MIR15_0); end
        push(32'h0000_AAAA, 16'h0);
        n_tests++; if (MIR15_0 !== 16'hAAAA) begin n_fail++; $display("FAIL post_flush_head got %h exp AAAA", MIR15_0); end
        n_tests++; if (CNT !== 3'd1) begin n_fail++; $display("FAIL post_flush_cnt got %0d exp 1", CNT); end
        pop();
    endtask

    task automatic test_lev_reset();
        push(32'h0000_A000, 16'h0);
        LSEL = 1'b1; PIL = 4'h5; #1;
        n_tests++; if (LEV !== 4'hA) begin n_fail++; $display("FAIL lev_lsel got %h exp A", LEV); end
        LSEL = 1'b0; MOPC = 1'b1; #1;
        n_tests++; if (LEV !== 4'h0) begin n_fail++; $display("FAIL lev_mopc got %h exp 0", LEV); end
        MOPC = 1'b0; #1;
        n_tests++; if (LEV !== 4'h5) begin n_fail++; $display("FAIL lev_pil got %h exp 5", LEV); end
        push(32'h0000_1357, 16'h0);
        ROM = 32'h0000_2468; MIRKL = 1'b1; MCLn = 1'b0;
        cyc();
        MIRKL = 1'b0; MCLn = 1'b1; PIL = 4'h0; #1;
        n_tests++; if (MIRV !== 1'b0) begin n_fail++; $display("FAIL mcl_mirv got %b exp 0", MIRV); end
        n_tests++; if (MIR15_0 !== 16'h0) begin n_fail++; $display("FAIL mcl_mir got %h exp 0000", MIR15_0); end
        n_tests++; if (CNT !== 3'd0) begin n_fail++; $display("FAIL mcl_cnt got %0d exp 0", CNT); end
        n_tests++; if (MIRRDY !== 1'b1) begin n_fail++; $display("FAIL mcl_mirrdy got %b exp 1", MIRRDY); end
        push(32'h0000_BEEF, 16'h0);
        n_tests++; if (MIR15_0 !== 16'hBEEF) begin n_fail++; $display("FAIL post_mcl_head got %h exp BEEF", MIR15_0); end
        pop();
    endtask

`ifdef MIRQ_PARITY_EN
    task automatic test_parity();
        n_tests++; if (MIRPE !== 1'b0) begin n_fail++; $display("FAIL pe_initial got %b exp 0", MIRPE); end
        ROMP = 1'b0;
        push(32'h0000_0001, 16'h0);
        n_tests++; if (MIRPE !== 1'b0) begin n_fail++; $display("FAIL pe_good got %b exp 0", MIRPE); end
        push(32'h0000_0003, 16'h0);
        n_tests++; if (MIRPE !== 1'b1) begin n_fail++; $display("FAIL pe_bad got %b exp 1", MIRPE); end
        n_tests++; if (CNT !== 3'd2) begin n_fail++; $display("FAIL pe_enqueued got %0d exp 2", CNT); end
        pop(); pop();
        n_tests++; if (MIRPE !== 1'b1) begin n_fail++; $display("FAIL pe_sticky got %b exp 1", MIRPE); end
        MCLn = 1'b0; cyc(); MCLn = 1'b1; #1;
        n_tests++; if (MIRPE !== 1'b0) begin n_fail++; $display("FAIL pe_clear got %b exp 0", MIRPE); end
    endtask
`endif

    initial begin
        MCLn = 1'b1; MIRKL = 1'b0; MIRNX = 1'b0; FLUSH = 1'b0; TC1 = 1'b0;
        LSEL = 1'b0; MOPC = 1'b0; PIL = 4'h0; ROM = 32'h0; IR = 16'h0;
`ifdef MIRQ_PARITY_EN
        ROMP = 1'b0;
`endif
        test_reset();
        test_code0();
        test_assembly();
        test_sl_bmsrc();
        test_full_wrap();
        test_flush();
        test_lev_reset();
`ifdef MIRQ_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
